// File: rtl/utils_pkg.sv
// Shared AXI types, encodings and helpers for the memory responder.
// Data width comes from the global AXI_DATA_WIDTH define (32 when unset).
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

package utils_pkg;

    localparam int DATA_W     = `AXI_DATA_WIDTH;
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int BYTE_SHIFT = $clog2(DATA_BYTES);
    localparam int ADDR_W     = 32;
    localparam int ID_W       = 4;

    typedef enum logic [1:0] {
        FIXED      = 2'b00,
        INCR       = 2'b01,
        WRAP       = 2'b10,
        BURST_RSVD = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

    typedef struct packed {
        logic [ID_W-1:0]       awid;
        logic [ADDR_W-1:0]     awaddr;
        logic [7:0]            awlen;
        logic [2:0]            awsize;
        logic [1:0]            awburst;
        logic                  awvalid;
        logic [DATA_W-1:0]     wdata;
        logic [DATA_BYTES-1:0] wstrb;
        logic                  wlast;
        logic                  wvalid;
        logic                  bready;
        logic [ID_W-1:0]       arid;
        logic [ADDR_W-1:0]     araddr;
        logic [7:0]            arlen;
        logic [2:0]            arsize;
        logic [1:0]            arburst;
        logic                  arvalid;
        logic                  rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic              awready;
        logic              wready;
        logic [ID_W-1:0]   bid;
        logic [1:0]        bresp;
        logic              bvalid;
        logic              arready;
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              rlast;
        logic              rvalid;
    } s_axi_miso_t;

    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] addr,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] step;
        step = ADDR_W'(1) << size;
        if (burst == INCR) return (addr & ~(step - 1)) + step;
        return addr;
    endfunction

    function automatic logic burst_bad(
        input logic [2:0] size,
        input logic [1:0] burst
    );
        return (burst == WRAP) || (burst == BURST_RSVD) ||
               (int'(size) > BYTE_SHIFT);
    endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// Word-wide RAM: one byte-enabled write port, one registered read port.
// A read and write to the same word in one cycle returns the old data.
module axi_mem_ram
    import utils_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int IDX_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_BYTES-1:0] wr_strb,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory responder with independent write and read FSMs.
// Define AXI_MEM_OOR_ERR_EN to flag out-of-range beats as SLVERR.
module axi_mem_slave
    import utils_pkg::*;
#(
    parameter int          MEM_SIZE_BYTES = 4096,
    parameter logic [31:0] BASE_ADDR      = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  s_axi_mosi_t axi_mosi_i,
    output s_axi_miso_t axi_miso_o
);

    localparam int WORDS = MEM_SIZE_BYTES / DATA_BYTES;
    localparam int IDX_W = $clog2(WORDS);
`ifdef AXI_MEM_OOR_ERR_EN
    localparam bit OOR_ERR = 1'b1;
`else
    localparam bit OOR_ERR = 1'b0;
`endif

    w_state_e          w_state;
    logic [ID_W-1:0]   w_id;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err, w_bad;
    logic              awready, wready, bvalid;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;

    r_state_e          r_state;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len, r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_bad, r_zero;
    logic              arready, rvalid, rlast;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;

    logic              w_oor, r_oor, w_beat_err;
    logic              wr_en, rd_en;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [DATA_W-1:0] ram_q;

    // Without the range check the index simply wraps inside the array.
    assign w_oor  = OOR_ERR &&
                    ((w_addr - BASE_ADDR) >= 32'(MEM_SIZE_BYTES));
    assign r_oor  = OOR_ERR &&
                    ((r_addr - BASE_ADDR) >= 32'(MEM_SIZE_BYTES));
    assign wr_idx = IDX_W'((w_addr - BASE_ADDR) >> BYTE_SHIFT);
    assign rd_idx = IDX_W'((r_addr - BASE_ADDR) >> BYTE_SHIFT);

    assign w_beat_err = w_err || w_oor ||
                        (axi_mosi_i.wlast != (w_cnt == w_len));
    assign wr_en = (w_state == W_DATA) && axi_mosi_i.wvalid &&
                   !w_bad && !w_oor;
    assign rd_en = (r_state == R_FETCH);

    axi_mem_ram #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_strb (axi_mosi_i.wstrb),
        .wr_data (axi_mosi_i.wdata),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
            w_bad   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awready && axi_mosi_i.awvalid) begin
                        w_id    <= axi_mosi_i.awid;
                        w_addr  <= axi_mosi_i.awaddr;
                        w_len   <= axi_mosi_i.awlen;
                        w_size  <= axi_mosi_i.awsize;
                        w_burst <= axi_mosi_i.awburst;
                        w_cnt   <= '0;
                        w_bad   <= burst_bad(axi_mosi_i.awsize,
                                             axi_mosi_i.awburst);
                        w_err   <= burst_bad(axi_mosi_i.awsize,
                                             axi_mosi_i.awburst);
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi_mosi_i.wvalid) begin
                        w_cnt  <= w_cnt + 8'd1;
                        w_addr <= next_addr(w_addr, w_size, w_burst);
                        w_err  <= w_beat_err;
                        // Beat count, not wlast, closes the burst.
                        if (w_cnt == w_len) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= w_id;
                            bresp   <= w_beat_err ? SLVERR : OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_mosi_i.bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_bad   <= 1'b0;
            r_zero  <= 1'b0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rresp   <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arready && axi_mosi_i.arvalid) begin
                        r_id    <= axi_mosi_i.arid;
                        r_addr  <= axi_mosi_i.araddr;
                        r_len   <= axi_mosi_i.arlen;
                        r_size  <= axi_mosi_i.arsize;
                        r_burst <= axi_mosi_i.arburst;
                        r_cnt   <= '0;
                        r_bad   <= burst_bad(axi_mosi_i.arsize,
                                             axi_mosi_i.arburst);
                        arready <= 1'b0;
                        r_state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rvalid  <= 1'b1;
                    rid     <= r_id;
                    rlast   <= (r_cnt == r_len);
                    rresp   <= (r_bad || r_oor) ? SLVERR : OKAY;
                    r_zero  <= r_bad || r_oor;
                    r_state <= R_DATA;
                end
                R_DATA: begin
                    if (axi_mosi_i.rready) begin
                        rvalid <= 1'b0;
                        if (rlast) begin
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_addr  <= next_addr(r_addr, r_size, r_burst);
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        axi_miso_o         = '0;
        axi_miso_o.awready = awready;
        axi_miso_o.wready  = wready;
        axi_miso_o.bvalid  = bvalid;
        axi_miso_o.bid     = bid;
        axi_miso_o.bresp   = bresp;
        axi_miso_o.arready = arready;
        axi_miso_o.rvalid  = rvalid;
        axi_miso_o.rid     = rid;
        axi_miso_o.rresp   = rresp;
        axi_miso_o.rlast   = rlast;
        axi_miso_o.rdata   = r_zero ? '0 : ram_q;
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized bench for axi_mem_slave against a byte-array memory model.
// Expected responses follow the AXI_MEM_OOR_ERR_EN setting of the build.
module tb_axi_mem_slave;
    import utils_pkg::*;

    localparam int          MEM   = 4096;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          WORDS = MEM / DATA_BYTES;
`ifdef AXI_MEM_OOR_ERR_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    s_axi_mosi_t mosi;
    s_axi_miso_t miso;

    int checks = 0;
    int errors = 0;

    logic [7:0]            ref_mem [MEM];
    logic [DATA_W-1:0]     wd [$];
    logic [DATA_BYTES-1:0] ws [$];

    axi_mem_slave #(
        .MEM_SIZE_BYTES (MEM),
        .BASE_ADDR      (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .axi_mosi_i (mosi),
        .axi_miso_o (miso)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_BYTES-1:0] rnd_strb();
        logic [31:0] r;
        r = $urandom();
        return r[DATA_BYTES-1:0];
    endfunction

    function automatic bit oor(input logic [31:0] a);
        return OOR_EN && ((a < BASE) || (a >= BASE + MEM));
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off / DATA_BYTES) % WORDS);
    endfunction

    function automatic logic [31:0] step_addr(input logic [31:0] a,
                                              input logic [2:0] size,
                                              input logic [1:0] burst);
        logic [31:0] sz;
        sz = 32'd1 << size;
        if (burst == INCR) return a - (a % sz) + sz;
        return a;
    endfunction

    function automatic bit bad_burst(input logic [2:0] size,
                                     input logic [1:0] burst);
        return burst == WRAP || burst == BURST_RSVD ||
               int'(size) > BYTE_SHIFT;
    endfunction

    task automatic model_wbeat(input logic [31:0] a,
                               input logic [DATA_W-1:0] d,
                               input logic [DATA_BYTES-1:0] s);
        for (int b = 0; b < DATA_BYTES; b++)
            if (s[b]) ref_mem[widx(a)*DATA_BYTES + b] = d[b*8 +: 8];
    endtask

    function automatic logic [DATA_W-1:0] model_rword(input logic [31:0] a);
        logic [DATA_W-1:0] w;
        for (int b = 0; b < DATA_BYTES; b++)
            w[b*8 +: 8] = ref_mem[widx(a)*DATA_BYTES + b];
        return w;
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                            input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int bad_last);
        bit          err;
        bit          last;
        logic [31:0] a;
        int          n;
        mosi.awid    = id;
        mosi.awaddr  = addr;
        mosi.awlen   = 8'(len);
        mosi.awsize  = size;
        mosi.awburst = burst;
        mosi.awvalid = 1'b1;
        n = 0;
        while (!miso.awready && n < 100) begin tick(); n++; end
        if (!miso.awready) begin
            check("aw_timeout", 0, 1);
            mosi.awvalid = 1'b0;
            return;
        end
        tick();
        mosi.awvalid = 1'b0;
        err = bad_burst(size, burst);
        a = addr;
        for (int i = 0; i <= len; i++) begin
            last = (bad_last >= 0) ? (i == bad_last) : (i == len);
            mosi.wvalid = 1'b1;
            mosi.wdata  = wd[i];
            mosi.wstrb  = ws[i];
            mosi.wlast  = last;
            n = 0;
            while (!miso.wready && n < 100) begin tick(); n++; end
            if (!miso.wready) begin
                check("w_timeout", 0, 1);
                mosi.wvalid = 1'b0;
                return;
            end
            if (i == 0) check("w_lat", 64'(n), 0);
            tick();
            if (!bad_burst(size, burst)) begin
                if (oor(a)) err = 1'b1;
                else model_wbeat(a, wd[i], ws[i]);
            end
            if (last != (i == len)) err = 1'b1;
            a = step_addr(a, size, burst);
        end
        mosi.wvalid = 1'b0;
        mosi.wlast  = 1'b0;
        n = 0;
        while (!miso.bvalid && n < 100) begin tick(); n++; end
        check("b_lat", 64'(n), 0);
        check("bresp", 64'(miso.bresp), err ? 64'(SLVERR) : 64'(OKAY));
        check("bid", 64'(miso.bid), 64'(id));
        mosi.bready = 1'b1;
        tick();
        mosi.bready = 1'b0;
        check("b_done", 64'(miso.bvalid), 0);
        check("aw_back", 64'(miso.awready), 1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                           input int len, input logic [2:0] size,
                           input logic [1:0] burst, input int stall,
                           output logic [DATA_W-1:0] d0);
        logic [31:0]       a;
        logic [DATA_W-1:0] exp_d;
        logic [1:0]        exp_r;
        int                n;
        d0 = '0;
        mosi.arid    = id;
        mosi.araddr  = addr;
        mosi.arlen   = 8'(len);
        mosi.arsize  = size;
        mosi.arburst = burst;
        mosi.arvalid = 1'b1;
        mosi.rready  = 1'b1;
        n = 0;
        while (!miso.arready && n < 100) begin tick(); n++; end
        if (!miso.arready) begin
            check("ar_timeout", 0, 1);
            mosi.arvalid = 1'b0;
            return;
        end
        tick();
        mosi.arvalid = 1'b0;
        a = addr;
        for (int i = 0; i <= len; i++) begin
            n = 0;
            while (!miso.rvalid && n < 100) begin tick(); n++; end
            if (!miso.rvalid) begin
                check("r_timeout", 0, 1);
                return;
            end
            check("r_lat", 64'(n), 1);
            if (bad_burst(size, burst) || oor(a)) begin
                exp_d = '0;
                exp_r = SLVERR;
            end else begin
                exp_d = model_rword(a);
                exp_r = OKAY;
            end
            if (i == 0) d0 = miso.rdata;
            check("rdata", 64'(miso.rdata), 64'(exp_d));
            check("rresp", 64'(miso.rresp), 64'(exp_r));
            check("rid", 64'(miso.rid), 64'(id));
            check("rlast", 64'(miso.rlast), 64'(i == len));
            if (i == stall) begin
                mosi.rready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    check("stall_v", 64'(miso.rvalid), 1);
                    check("stall_d", 64'(miso.rdata), 64'(exp_d));
                    check("stall_l", 64'(miso.rlast), 64'(i == len));
                end
                mosi.rready = 1'b1;
            end
            tick();
            a = step_addr(a, size, burst);
        end
        check("r_done", 64'(miso.rvalid), 0);
    endtask

    task automatic fill(input int len, input bit full_strb);
        wd.delete();
        ws.delete();
        for (int i = 0; i <= len; i++) begin
            wd.push_back(rnd_word());
            ws.push_back(full_strb ? '1 : rnd_strb());
        end
    endtask

    logic [DATA_W-1:0]     d0;
    logic [DATA_BYTES-1:0] full;
    logic [2:0]            fsz;
    int                    len, bl, cnt;
    logic [31:0]           addr;
    logic [2:0]            sz;
    logic [1:0]            bt;

    initial begin
        mosi = '0;
        full = '1;
        fsz  = 3'(BYTE_SHIFT);
        repeat (3) tick();
        check("rst_rdy", {miso.awready, miso.wready, miso.arready,
                          miso.bvalid, miso.rvalid, miso.rlast}, 0);
        check("rst_data", 64'(miso.rdata), 0);
        check("rst_ids", {miso.bid, miso.rid, miso.bresp, miso.rresp}, 0);
        rst = 1'b0;
        check("aw_pre", 64'(miso.awready), 0);
        tick();
        check("aw_post", 64'(miso.awready), 1);
        check("ar_post", 64'(miso.arready), 1);

        for (int k = 0; k < MEM / (256 * DATA_BYTES); k++) begin
            fill(255, 1'b1);
            do_write(4'(k), BASE + 32'(k * 256 * DATA_BYTES), 255, fsz,
                     INCR, -1);
        end

        wd = '{DATA_W'(32'hDEADBEEF)};
        ws = '{DATA_BYTES'(4'hF)};
        do_write(4'h3, BASE + 32'h10, 0, 3'd2, INCR, -1);
        do_read(4'h5, BASE + 32'h10, 0, 3'd2, INCR, -1, d0);
        check("single", 64'(d0[31:0]), 64'h0000_0000_DEAD_BEEF);

        wd.delete();
        ws.delete();
        for (int i = 0; i < 8; i++) begin
            wd.push_back(DATA_W'(i));
            ws.push_back(full);
        end
        do_write(4'h7, BASE + 32'h100, 7, 3'd2, INCR, -1);
        do_read(4'h9, BASE + 32'h100, 7, 3'd2, INCR, -1, d0);

        wd = '{DATA_W'(32'h11), DATA_W'(32'h2200),
               DATA_W'(32'h330000), DATA_W'(32'h44000000)};
        ws = '{DATA_BYTES'(1), DATA_BYTES'(2),
               DATA_BYTES'(4), DATA_BYTES'(8)};
        do_write(4'h1, BASE + 32'h40, 3, 3'd2, FIXED, -1);
        do_read(4'h2, BASE + 32'h40, 0, 3'd2, INCR, -1, d0);
        check("fixed", 64'(d0[31:0]), 64'h0000_0000_4433_2211);

        fill(3, 1'b1);
        do_write(4'hA, BASE + 32'h200, 3, 3'd2, WRAP, -1);
        do_read(4'hB, BASE + 32'h200, 3, 3'd2, INCR, -1, d0);
        fill(3, 1'b1);
        do_write(4'hC, BASE + 32'h300, 3, 3'd2, INCR, 1);

        wd = '{DATA_W'(32'hCAFEF00D)};
        ws = '{full};
        do_write(4'hD, BASE + MEM, 0, fsz, INCR, -1);
        do_read(4'hE, BASE, 0, fsz, INCR, -1, d0);

        fill(7, 1'b1);
        do_write(4'h4, BASE + 32'h400, 7, fsz, INCR, -1);
        do_read(4'h6, BASE + 32'h400, 7, fsz, INCR, 3, d0);

        for (int it = 0; it < 40; it++) begin
            addr = BASE + 32'($urandom_range(0, MEM + 255));
            len  = $urandom_range(0, 15);
            sz   = 3'($urandom_range(0, BYTE_SHIFT));
            bt   = ($urandom_range(0, 1) == 1) ? INCR : FIXED;
            if ($urandom_range(0, 9) == 0) bt = 2'($urandom_range(2, 3));
            if ($urandom_range(0, 9) == 0) sz = 3'(BYTE_SHIFT + 1);
            if ($urandom_range(0, 1) == 1) begin
                bl = ($urandom_range(0, 9) == 0) ?
                     int'($urandom_range(0, len)) : -1;
                fill(len, $urandom_range(0, 1) == 1);
                do_write(4'($urandom()), addr, len, sz, bt, bl);
            end else begin
                bl = ($urandom_range(0, 4) == 0) ?
                     int'($urandom_range(0, len)) : -1;
                do_read(4'($urandom()), addr, len, sz, bt, bl, d0);
            end
        end

        mosi.awid    = 4'h8;
        mosi.awaddr  = BASE + 32'h600;
        mosi.awlen   = 8'd15;
        mosi.awsize  = fsz;
        mosi.awburst = INCR;
        mosi.awvalid = 1'b1;
        cnt = 0;
        while (!miso.awready && cnt < 100) begin tick(); cnt++; end
        tick();
        mosi.awvalid = 1'b0;
        addr = BASE + 32'h600;
        for (int i = 0; i < 6; i++) begin
            mosi.wvalid = 1'b1;
            mosi.wdata  = rnd_word();
            mosi.wstrb  = full;
            mosi.wlast  = 1'b0;
            cnt = 0;
            while (!miso.wready && cnt < 100) begin tick(); cnt++; end
            tick();
            model_wbeat(addr, mosi.wdata, mosi.wstrb);
            addr = addr + DATA_BYTES;
        end
        rst = 1'b1;
        mosi.wvalid = 1'b0;
        #1;
        check("mid_rst_rdy", {miso.awready, miso.wready, miso.arready,
                              miso.bvalid, miso.rvalid, miso.rlast}, 0);
        check("mid_rst_ids", {miso.bid, miso.rid, miso.bresp,
                              miso.rresp}, 0);
        check("mid_rst_data", 64'(miso.rdata), 0);
        tick();
        tick();
        rst = 1'b0;
        check("rel_aw_pre", 64'(miso.awready), 0);
        tick();
        check("rel_aw_post", 64'(miso.awready), 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (miso.bvalid) cnt++;
            tick();
        end
        check("stale_b", 64'(cnt), 0);
        do_read(4'h2, BASE + 32'h600, 15, fsz, INCR, -1, d0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
